// File: rtl/mem_pkg.sv
// Shared definitions for the write sequencer and its target memory:
// default geometry, address width derivation and sequencer state encoding.
package mem_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Word address width for a memory of the given depth (at least one bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_write_seq_if.sv
// Control, stream and memory-write signals of the write sequencer, bundled
// with a master (requester/stream source) and slave (sequencer) view.
interface mem_write_seq_if
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
);
    localparam int unsigned ADDR_W = addr_w(DEPTH);

    logic              start;
    logic              fill_mode;
    logic [WIDTH-1:0]  pattern;
    logic              abort;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              busy;
    logic              done;

    modport master (
        output start, fill_mode, pattern, abort, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  start, fill_mode, pattern, abort, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done
    );

endinterface

// File: rtl/mem_addr_cnt.sv
// Word address counter for the write sequencer: synchronous clear, increment,
// and a registered flag that is high while the count equals DEPTH-1.
module mem_addr_cnt
    import mem_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_q, last_d;

    // The last flag is precomputed on the increment that reaches DEPTH-1.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clr_i) begin
            cnt_d  = '0;
            last_d = 1'b0;
        end else if (inc_i) begin
            cnt_d  = cnt_q + ADDR_W'(1);
            last_d = (cnt_q == ADDR_W'(DEPTH - 2));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = last_q;

endmodule

// File: rtl/mem_write_seq.sv
// Memory write sequencer: fills every word with a latched pattern or loads
// DEPTH words from a valid/ready stream, then pulses done once.
module mem_write_seq
    import mem_pkg::*;
#(
    parameter  int unsigned WIDTH  = WIDTH_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_write_seq_if.slave   bus
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  pattern_q, pattern_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic [ADDR_W-1:0] cnt;
    logic              cnt_last;

    mem_addr_cnt #(
        .DEPTH (DEPTH)
    ) u_addr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // The counter rests at zero in IDLE, so a fill can issue word 0 on start.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.start) begin
                    pattern_d = bus.pattern;
                    if (bus.fill_mode) begin
                        state_d = ST_FILL;
                        we_d    = 1'b1;
                        addr_d  = '0;
                        wdata_d = bus.pattern;
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_FILL: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = cnt;
                    wdata_d = pattern_q;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                // Abort wins over a handshake in the same cycle.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (bus.in_valid) begin
                    we_d    = 1'b1;
                    addr_d  = cnt;
                    wdata_d = bus.in_data;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        busy_d = (state_d == ST_FILL) || (state_d == ST_STREAM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_STREAM);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: doc/mem_write_seq.md
MEM_WRITE_SEQ -- requirements
Module: mem_write_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width of the target memory in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of words in the target memory (need not be a power of two, minimum 2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sequence, sampled in IDLE only.
REQ-006 SHALL have port fill_mode  input  1  sampled with start: 1 = pattern fill, 0 = stream load.
REQ-007 SHALL have port pattern  input  WIDTH  fill word, sampled with start.
REQ-008 SHALL have port abort  input  1  synchronous cancel of the current sequence.
REQ-009 SHALL have port in_valid  input  1  stream word valid.
REQ-010 SHALL have port in_data  input  WIDTH  stream word.
REQ-011 SHALL have port in_ready  output  1  stream word accepted when in_valid and in_ready are both high.
REQ-012 SHALL have port mem_we  output  1  registered write enable to the memory.
REQ-013 SHALL have port mem_addr  output  ADDR_W  registered word address, ADDR_W = clog2(DEPTH).
REQ-014 SHALL have port mem_wdata  output  WIDTH  registered write data.
REQ-015 SHALL have port busy  output  1  high in FILL or STREAM.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last write of a completed sequence.

Function
REQ-017 SHALL implement states IDLE, FILL, STREAM, DONE.
REQ-018 IDLE: start=1 SHALL latch pattern and go to FILL if fill_mode=1, else STREAM; address counter cleared to 0.
REQ-019 FILL: SHALL issue one write per cycle, mem_we=1, mem_addr = 0..DEPTH-1 consecutively, mem_wdata = latched pattern; first write visible the cycle after start is sampled.
REQ-020 FILL: after the write to DEPTH-1 is issued SHALL go to DONE; a full fill therefore spans exactly DEPTH cycles of mem_we.
REQ-021 STREAM: in_ready SHALL be combinationally high; in other states it SHALL be 0, and in_valid SHALL be ignored.
REQ-022 STREAM: each handshake in cycle n SHALL produce mem_we=1, mem_addr = count, mem_wdata = in_data in cycle n+1; no handshake leaves mem_we=0 and count unchanged.
REQ-023 STREAM: the handshake at count DEPTH-1 SHALL be the last; the state SHALL then go to DONE, with no address wrap and no write beyond DEPTH-1.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 start in any state other than IDLE SHALL be ignored.
REQ-026 abort in FILL or STREAM SHALL return to IDLE on the next edge, suppress any write for that cycle (mem_we=0 next cycle), and leave done low; abort has priority over a simultaneous handshake.
REQ-027 abort in IDLE or DONE SHALL have no effect.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, count=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, in_ready=0, latched pattern=0.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence with no further writes; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-031 WIDTH/DEPTH defaults, ADDR_W derivation and state encodings SHALL live in a shared package/include (mem_pkg) used by this block and the memory.
REQ-032 The address counter (clear, increment, last-flag at DEPTH-1) SHALL be a sub-module mem_addr_cnt.

Verification
REQ-033 Fill: WIDTH=8, DEPTH=16, start with fill_mode=1, pattern=8'h02 -> mem_we high 16 consecutive cycles, addr 0..15, data 8'h02, done pulse on the next cycle.
REQ-034 Stream with gaps: 16 words 8'hA0+i, in_valid toggled every other cycle -> 16 writes in order, each one cycle after its handshake, done once after the last.
REQ-035 Abort: fill started, abort at addr 5 -> writes 0..4 only, mem_we=0 after, done never asserted, busy low next cycle.
REQ-036 Reset mid-stream: rst_n low after 7 handshakes -> outputs zero asynchronously; a new start after release writes from addr 0.
REQ-037 Ignore rules: start pulsed during FILL and in_valid held high in IDLE -> no extra writes, no sequence restart.
REQ-038 Non-power-of-two: DEPTH=12 stream -> last write at addr 11, done, no write at addr 12 or 0.
